div_unit: RTL and testbench

- Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) in the EX stage, alongside the single-cycle ALU.
- The ALU covers only single-cycle ops. This block is the multi-cycle path the pipeline stalls on.
- Radix-2 restoring divider: one quotient bit per cycle, with a start/busy/done handshake to the hazard/stall logic.

---
 rtl/rv32m_pkg.sv | 29 ++
 rtl/div_unit_if.sv | 24 ++
 rtl/div_unit_step.sv | 25 ++
 rtl/div_unit.sv | 124 ++++++++++++
 tb/tb_div_unit.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: op encodings, divider FSM states and the
// architecturally defined special-case constants.
package rv32m_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [RV_XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [RV_XLEN-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic op_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX-stage issue logic and div_unit.
interface div_unit_if;
  import rv32m_pkg::*;

  logic               start;
  logic               flush;
  logic [1:0]         op;
  logic [RV_XLEN-1:0] a;
  logic [RV_XLEN-1:0] b;
  logic               busy;
  logic               done;
  logic [RV_XLEN-1:0] result;

  modport master (
    output start, flush, op, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, op, a, b,
    output busy, done, result
  );

endinterface

// File: rtl/div_unit_step.sv
// One restoring-division bit: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and shift the quotient bit in.
module div_unit_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] dvd_in,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] dvd_out
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          ge;

  // rem_in < dvs always holds, so rem_sh < 2*dvs and the borrow bit of the
  // 33-bit difference is an exact "rem_sh < dvs" flag.
  assign rem_sh  = {rem_in, dvd_in[XLEN-1]};
  assign diff    = rem_sh - {1'b0, dvs};
  assign ge      = ~diff[XLEN];
  assign rem_out = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign dvd_out = {dvd_in[XLEN-2:0], ge};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU. The dividend
// register doubles as the quotient shift register during RUN.
module div_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg;
  logic [XLEN-1:0]   dvd_reg, dvs_reg, rem_reg, result_reg;
  logic              neg_q_reg, neg_r_reg, rem_sel_reg;

  logic              accept, busy, done;
  logic              sgn, a_neg, b_neg, is_div0, is_ovf, special;
  logic [XLEN-1:0]   abs_a, abs_b, rem_step, dvd_step, q_fix, r_fix, fin_val;

  assign sgn     = op_signed(bus.op);
  assign a_neg   = sgn & bus.a[XLEN-1];
  assign b_neg   = sgn & bus.b[XLEN-1];
  assign abs_a   = a_neg ? (~bus.a + 1'b1) : bus.a;
  assign abs_b   = b_neg ? (~bus.b + 1'b1) : bus.b;
  assign is_div0 = (bus.b == '0);
  assign is_ovf  = sgn && (bus.a == INT_MIN) && (bus.b == DIV0_QUOT);
  assign special = is_div0 | is_ovf;

  div_unit_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_reg),
    .dvd_in  (dvd_reg),
    .dvs     (dvs_reg),
    .rem_out (rem_step),
    .dvd_out (dvd_step)
  );

  // Sign fix-up happens in FIN so the RUN-cycle path stays a single step.
  assign q_fix   = neg_q_reg ? (~dvd_reg + 1'b1) : dvd_reg;
  assign r_fix   = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
  assign fin_val = rem_sel_reg ? r_fix : q_fix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          accept     = 1'b1;
          state_next = special ? FIN : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (bus.flush) begin
          state_next = IDLE;
        end else if (count_reg == '0) begin
          state_next = FIN;
        end
      end
      FIN: begin
        done       = !bus.flush;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg   <= '0;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      rem_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      rem_sel_reg <= 1'b0;
      result_reg  <= '0;
    end else begin
      if (accept) begin
        rem_sel_reg <= op_is_rem(bus.op);
        dvs_reg     <= abs_b;
        count_reg   <= CNT_W'(XLEN - 1);
        if (special) begin
          // Park the architectural answer in the quotient/remainder
          // registers so FIN selects it like a normal result.
          neg_q_reg <= 1'b0;
          neg_r_reg <= 1'b0;
          dvd_reg   <= is_div0 ? DIV0_QUOT : INT_MIN;
          rem_reg   <= is_div0 ? bus.a : '0;
        end else begin
          neg_q_reg <= a_neg ^ b_neg;
          neg_r_reg <= a_neg;
          dvd_reg   <= abs_a;
          rem_reg   <= '0;
        end
      end else if (state_reg == RUN) begin
        rem_reg   <= rem_step;
        dvd_reg   <= dvd_step;
        count_reg <= count_reg - 1'b1;
      end
      if (done) begin
        result_reg <= fin_val;
      end
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = done ? fin_val : result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases with literal
// expectations plus randomized traffic against a cycle-level reference model.
module tb_div_unit;
  import rv32m_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if bus ();

  div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Architectural answer from the RISC-V rules using plain SV arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    logic        sgn;
    sgn = (op == OP_DIV) || (op == OP_REM);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return (op == OP_REM || op == OP_REMU) ? r : q;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    logic sgn;
    sgn = (op == OP_DIV) || (op == OP_REM);
    if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // Reference model: cycles left until the done cycle, pending and committed result.
  bit          m_active = 1'b0;
  int          m_left   = 0;
  logic [31:0] m_pend   = '0;
  logic [31:0] m_res    = '0;
  bit          chk_en   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_left   = 0;
      m_res    = '0;
    end else if (m_active) begin
      if (bus.flush) begin
        m_active = 1'b0;
      end else if (m_left == 1) begin
        m_active = 1'b0;
        m_res    = m_pend;
      end else begin
        m_left--;
      end
    end else if (bus.start && !bus.flush) begin
      m_active = 1'b1;
      m_left   = ref_latency(bus.op, bus.a, bus.b);
      m_pend   = ref_result(bus.op, bus.a, bus.b);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_done;
      logic exp_busy;
      exp_done = m_active && (m_left == 1);
      exp_busy = m_active && (m_left > 1);
      check32("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
      check32("done", {31'd0, bus.done}, {31'd0, exp_done});
      check32("result", bus.result, exp_done ? m_pend : m_res);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Bounded wait for done; lat counts cycles from the current one (1-based).
  task automatic wait_done(input int max_cyc, output bit seen, output int lat,
                           output logic [31:0] res);
    seen = 1'b0;
    lat  = 0;
    res  = '0;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        lat  = n;
        res  = bus.result;
        break;
      end
    end
    tick();
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    bit          seen;
    int          lat;
    logic [31:0] res;
    issue(op, a, b);
    wait_done(40, seen, lat, res);
    $display("op %s op=%0d a=%h b=%h -> result=%h latency=%0d", name, op, a, b, res, lat);
    check32({name, " seen"}, {31'd0, seen}, 32'd1);
    check32({name, " latency"}, lat, exp_lat);
    check32({name, " value"}, res, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          seen;
    int          lat;
    logic [31:0] res;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = OP_DIV;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check32("reset busy", {31'd0, bus.busy}, 32'd0);
    check32("reset done", {31'd0, bus.done}, 32'd0);
    check32("reset result", bus.result, 32'd0);
    tick();

    do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, 1);
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Flush in cycle T+10: no done, busy low in T+11, result keeps 14.
    do_op("divu_pre_flush", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    check32("flush busy", {31'd0, bus.busy}, 32'd0);
    wait_done(40, seen, lat, res);
    $display("op flush_divu seen_done=%0d result=%h", seen, bus.result);
    check32("flush no done", {31'd0, seen}, 32'd0);
    check32("flush result kept", bus.result, 32'd14);

    // A second start at T+5 with different operands must be ignored.
    issue(OP_DIVU, 32'd77, 32'd5);
    repeat (4) tick();
    issue(OP_REMU, 32'd9, 32'd4);
    wait_done(40, seen, lat, res);
    $display("op ignored_start seen=%0d latency=%0d result=%h", seen, lat + 5, res);
    check32("ignore seen", {31'd0, seen}, 32'd1);
    check32("ignore latency", lat + 5, 33);
    check32("ignore value", res, 32'd15);
    wait_done(40, seen, lat, res);
    check32("ignore single done", {31'd0, seen}, 32'd0);

    // Reset at T+20 mid-run, then a normal op completes.
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    $display("op midrun_reset busy=%0d done=%0d result=%h", bus.busy, bus.done, bus.result);
    check32("midrst busy", {31'd0, bus.busy}, 32'd0);
    check32("midrst done", {31'd0, bus.done}, 32'd0);
    check32("midrst result", bus.result, 32'd0);
    tick();
    do_op("div_after_rst", OP_DIV, 32'h1234_5678, 32'hFFFF_FFF0, 32'hFEDC_BA99, 33);

    // Randomized traffic; the compare process checks every cycle.
    for (int it = 0; it < 60; it++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;
      int          k;
      int          tl;
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin
        b = 32'hFFFF_FFFF;
        if ($urandom_range(0, 1) == 1) a = 32'h8000_0000;
      end else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) begin
        a = 32'($urandom_range(0, 200));
        b = 32'($urandom_range(1, 300));
      end
      tl = ref_latency(op, a, b);
      k  = (tl == 33 && $urandom_range(0, 5) == 0) ? $urandom_range(1, 32) : 0;
      $display("op rand%0d op=%0d a=%h b=%h expect=%h flush_at=%0d", it, op, a, b,
               ref_result(op, a, b), k);
      issue(op, a, b);
      for (int i = 1; i <= tl; i++) begin
        bus.start = ($urandom_range(0, 3) == 0);
        bus.flush = (i == k);
        bus.op    = 2'($urandom_range(0, 3));
        bus.a     = $urandom;
        bus.b     = $urandom;
        tick();
        if (i == k) break;
      end
      bus.start = 1'b0;
      bus.flush = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
